// File: rtl/drbg_pkg.sv
// Shared widths, FSM state encoding and response error codes for the
// CTR_DRBG state controller.
package drbg_pkg;

    localparam int KEY_W    = 256;
    localparam int V_W      = 128;
    localparam int CTR_W    = 32;
    localparam int ADDIN_W  = 384;
    localparam int MAX_BITS = 256;

    typedef enum logic [2:0] {
        UNINST = 3'd0,
        IDLE   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_GEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    // A request length is usable only in 1..MAX_BITS.
    function automatic logic bits_legal(input logic [31:0] bits);
        return (bits != 32'd0) && (bits <= 32'(MAX_BITS));
    endfunction

endpackage

// File: rtl/drbg_state_ctrl_bit_mask.sv
// MSB-aligned keep-mask: the top req_bits bits are 1, the rest 0.
import drbg_pkg::*;

module drbg_state_ctrl_bit_mask (
    input  logic [31:0]         req_bits,
    output logic [MAX_BITS-1:0] mask
);

    // Bit (MAX_BITS-1-i) survives when it lies within the first req_bits bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            mask[MAX_BITS-1-i] = (32'(i) < req_bits);
        end
    end

endmodule

// File: rtl/drbg_state_ctrl.sv
// CTR_DRBG working-state owner and generate_drbg initiator.
// Optional feature macro: DRBG_TIMEOUT_EN adds a gen_done watchdog in WAIT.
//
// state  | meaning
// UNINST | no working state yet; only a load (instantiate) is accepted
// IDLE   | instantiated; accepts reseed loads and generate requests
// START  | one-cycle gen_start pulse to generate_drbg
// WAIT   | waiting for gen_done (or watchdog expiry)
// RESP   | response held on out_* until out_ready
import drbg_pkg::*;

module drbg_state_ctrl #(
    parameter logic [CTR_W-1:0] RESEED_INTERVAL = 32'h0001_0000,
    parameter int               TIMEOUT_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [KEY_W-1:0]    load_key,
    input  logic [V_W-1:0]      load_v,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_bits,
    input  logic [ADDIN_W-1:0]  req_addin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MAX_BITS-1:0] out_data,
    output logic                out_error,
    output logic [1:0]          out_err_code,
    output logic                gen_start,
    output logic [KEY_W-1:0]    gen_key,
    output logic [V_W-1:0]      gen_v,
    output logic [CTR_W-1:0]    gen_reseed_counter,
    output logic [ADDIN_W-1:0]  gen_additional_input,
    output logic [31:0]         gen_requested_bits,
    input  logic [KEY_W-1:0]    gen_key_out,
    input  logic [V_W-1:0]      gen_v_out,
    input  logic [CTR_W-1:0]    gen_reseed_counter_out,
    input  logic [MAX_BITS-1:0] gen_random_bits,
    input  logic                gen_done,
    input  logic                gen_error,
    output logic                instantiated,
    output logic                reseed_required
);

    ctrl_state_e          state_q, state_d;
    logic [KEY_W-1:0]     key_q;
    logic [V_W-1:0]       v_q;
    logic [CTR_W-1:0]     ctr_q;
    logic [ADDIN_W-1:0]   addin_q;
    logic [31:0]          bits_q;
    logic [MAX_BITS-1:0]  data_q;
    logic [MAX_BITS-1:0]  keep_mask;
    err_code_e            err_q;
    logic                 inst_q;
    logic                 load_fire;
    logic                 req_fire;
    logic                 req_len_ok;
    logic                 tmr_expired;

    drbg_state_ctrl_bit_mask u_bit_mask (
        .req_bits (bits_q),
        .mask     (keep_mask)
    );

    // Handshake readys are held low while reset is asserted.
    assign load_ready      = !rst && ((state_q == UNINST) || (state_q == IDLE));
    assign reseed_required = (ctr_q > RESEED_INTERVAL);
    assign req_ready       = !rst && (state_q == IDLE) && !load_valid && !reseed_required;
    assign load_fire       = load_valid && load_ready;
    assign req_fire        = req_valid && req_ready;
    assign req_len_ok      = bits_legal(req_bits);

    assign gen_start            = (state_q == START);
    assign gen_key              = key_q;
    assign gen_v                = v_q;
    assign gen_reseed_counter   = ctr_q;
    assign gen_additional_input = addin_q;
    assign gen_requested_bits   = bits_q;

    assign out_valid    = (state_q == RESP);
    assign out_data     = data_q;
    assign out_err_code = err_q;
    assign out_error    = out_valid && (err_q != ERR_OK);
    assign instantiated = inst_q;

`ifdef DRBG_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] tmr_q;

    assign tmr_expired = (tmr_q == '0);

    // Watchdog down-counter: loaded on the way into WAIT, expires after TIMEOUT_CYCLES WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (state_q == START) begin
            tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == WAIT) && !tmr_expired) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end
`else
    assign tmr_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNINST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; gen_done takes priority over watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNINST: if (load_fire) state_d = IDLE;
            IDLE:   if (req_fire)  state_d = req_len_ok ? START : RESP;
            START:  state_d = WAIT;
            WAIT:   if (gen_done || tmr_expired) state_d = RESP;
            RESP:   if (out_ready) state_d = IDLE;
            default: state_d = UNINST;
        endcase
    end

    // Working state, request latches and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            v_q     <= '0;
            ctr_q   <= '0;
            addin_q <= '0;
            bits_q  <= '0;
            data_q  <= '0;
            err_q   <= ERR_OK;
            inst_q  <= 1'b0;
        end else begin
            case (state_q)
                UNINST, IDLE: begin
                    if (load_fire) begin
                        key_q  <= load_key;
                        v_q    <= load_v;
                        ctr_q  <= CTR_W'(1);
                        inst_q <= 1'b1;
                    end else if (req_fire) begin
                        bits_q  <= req_bits;
                        addin_q <= req_addin;
                        data_q  <= '0;
                        err_q   <= req_len_ok ? ERR_OK : ERR_BAD_LEN;
                    end
                end
                WAIT: begin
                    if (gen_done) begin
                        if (gen_error) begin
                            err_q  <= ERR_GEN;
                            data_q <= '0;
                        end else begin
                            key_q  <= gen_key_out;
                            v_q    <= gen_v_out;
                            ctr_q  <= gen_reseed_counter_out;
                            err_q  <= ERR_OK;
                            data_q <= gen_random_bits & keep_mask;
                        end
                    end else if (tmr_expired) begin
                        err_q  <= ERR_TIMEOUT;
                        data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_drbg_state_ctrl.sv
// Directed bench for drbg_state_ctrl with a small generate_drbg responder.
import drbg_pkg::*;

module tb_drbg_state_ctrl;

    localparam logic [31:0] RI = 32'h0001_0000;
    localparam int          TO = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_valid, load_ready;
    logic [255:0]        load_key;
    logic [127:0]        load_v;
    logic                req_valid, req_ready;
    logic [31:0]         req_bits;
    logic [383:0]        req_addin;
    logic                out_valid, out_ready;
    logic [255:0]        out_data;
    logic                out_error;
    logic [1:0]          out_err_code;
    logic                gen_start;
    logic [255:0]        gen_key;
    logic [127:0]        gen_v;
    logic [31:0]         gen_reseed_counter;
    logic [383:0]        gen_additional_input;
    logic [31:0]         gen_requested_bits;
    logic [255:0]        gen_key_out;
    logic [127:0]        gen_v_out;
    logic [31:0]         gen_reseed_counter_out;
    logic [255:0]        gen_random_bits;
    logic                gen_done;
    logic                gen_error;
    logic                instantiated, reseed_required;

    // responder configuration
    logic                m_respond, m_err, m_ctr_ovr, m_kick, m_busy;
    logic [7:0]          m_delay, m_cnt;
    logic [31:0]         m_ctr_val;
    logic [255:0]        m_key_out;
    logic [127:0]        m_v_out;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;

    localparam logic [255:0] R  = {8{32'hA5C3_96F0}};
    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] V1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K2 = {8{32'hDEAD_BEEF}};
    localparam logic [127:0] V2 = {4{32'hCAFE_F00D}};
    localparam logic [255:0] K3 = {8{32'h1357_9BDF}};
    localparam logic [127:0] V3 = {4{32'h2468_ACE0}};

    drbg_state_ctrl #(.RESEED_INTERVAL(RI), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_key(load_key), .load_v(load_v),
        .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits), .req_addin(req_addin),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_error(out_error), .out_err_code(out_err_code),
        .gen_start(gen_start), .gen_key(gen_key), .gen_v(gen_v),
        .gen_reseed_counter(gen_reseed_counter), .gen_additional_input(gen_additional_input),
        .gen_requested_bits(gen_requested_bits), .gen_key_out(gen_key_out), .gen_v_out(gen_v_out),
        .gen_reseed_counter_out(gen_reseed_counter_out), .gen_random_bits(gen_random_bits),
        .gen_done(gen_done), .gen_error(gen_error),
        .instantiated(instantiated), .reseed_required(reseed_required)
    );

    always #5 clk = ~clk;

    assign gen_key_out            = m_key_out;
    assign gen_v_out              = m_v_out;
    assign gen_random_bits        = R;
    assign gen_error              = m_err;
    assign gen_reseed_counter_out = m_ctr_ovr ? m_ctr_val : gen_reseed_counter + 32'd1;

    // generate_drbg stand-in: gen_done m_delay+1 cycles after gen_start
    always @(posedge clk) begin
        gen_done <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 8'd0) begin
                gen_done <= 1'b1;
                m_busy   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 8'd1;
            end
        end else if (gen_start && m_respond) begin
            m_busy <= 1'b1;
            m_cnt  <= m_delay;
        end else if (m_kick) begin
            gen_done <= 1'b1;
        end
    end

    // cycle counter and gen_start pulse monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gen_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [255:0] k, input logic [127:0] v);
        int n = 0;
        @(negedge clk);
        load_valid = 1'b1; load_key = k; load_v = v;
        #1;
        while (!load_ready && n < 100) begin @(negedge clk); n++; end
        chk("load_handshake", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] bits, input logic [383:0] addin);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_bits = bits; req_addin = addin;
        #1;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_handshake", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [255:0] d, output logic [1:0] code, output logic err);
        int n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("resp_handshake", out_valid, 1);
        d = out_data; code = out_err_code; err = out_error;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0]  bits;
        logic         gen_err;
        logic [1:0]   code;
        logic [255:0] data;
        int           starts;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [255:0] d, d0, exp_key;
        logic [127:0] exp_v;
        logic [31:0]  exp_ctr;
        logic [1:0]   code;
        logic         err;
        logic [383:0] addin;
        int           s0, s1, n;

        tbl[0] = '{32'd8,   1'b0, 2'd0, {8'hA5, 248'h0}, 1};
        tbl[1] = '{32'd1,   1'b0, 2'd0, {1'b1, 255'h0}, 1};
        tbl[2] = '{32'd100, 1'b0, 2'd0, {96'hA5C396F0A5C396F0A5C396F0, 4'hA, 156'h0}, 1};
        tbl[3] = '{32'd0,   1'b0, 2'd1, 256'h0, 0};
        tbl[4] = '{32'd257, 1'b0, 2'd1, 256'h0, 0};
        tbl[5] = '{32'd12,  1'b1, 2'd2, 256'h0, 1};
        tbl[6] = '{32'd40,  1'b0, 2'd0, {32'hA5C396F0, 8'hA5, 216'h0}, 1};

        rst = 1'b1;
        load_valid = 0; load_key = '0; load_v = '0;
        req_valid = 0; req_bits = '0; req_addin = '0; out_ready = 0;
        m_respond = 1; m_err = 0; m_ctr_ovr = 0; m_kick = 0; m_delay = 8'd2;
        m_ctr_val = '0; m_key_out = K2; m_v_out = V2;

        repeat (3) @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instantiated", instantiated, 0);
        chk("rst_key", gen_key, 0);
        chk("rst_ctr", gen_reseed_counter, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("uninst_load_ready", load_ready, 1);
        chk("uninst_req_ready", req_ready, 0);

        // instantiate, full-width generate
        do_load(K1, V1);
        chk("inst_flag", instantiated, 1);
        chk("inst_key", gen_key, K1);
        chk("inst_v", gen_v, V1);
        chk("inst_ctr", gen_reseed_counter, 1);
        s0 = start_cnt;
        send_req(32'd256, '0);
        get_resp(d, code, err);
        chk("t1_code", code, 0);
        chk("t1_err", err, 0);
        chk("t1_data", d, R);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_key", gen_key, K2);
        chk("t1_v", gen_v, V2);
        chk("t1_ctr", gen_reseed_counter, 2);
        exp_key = K2; exp_v = V2; exp_ctr = 32'd2;

        // table of requests: masking, bad lengths, generate error
        for (int i = 0; i < 7; i++) begin
            m_key_out = {8{32'(i + 1)}};
            m_v_out   = {4{32'(i + 256)}};
            m_err     = tbl[i].gen_err;
            addin     = {12{32'(i + 1)}};
            s0 = start_cnt;
            send_req(tbl[i].bits, addin);
            get_resp(d, code, err);
            chk($sformatf("v%0d_data", i), d, tbl[i].data);
            chk($sformatf("v%0d_code", i), code, tbl[i].code);
            chk($sformatf("v%0d_err", i), err, tbl[i].code != 2'd0);
            chk($sformatf("v%0d_starts", i), start_cnt - s0, tbl[i].starts);
            chk($sformatf("v%0d_reqbits", i), gen_requested_bits, tbl[i].bits);
            chk($sformatf("v%0d_addin", i), gen_additional_input, addin);
            if (tbl[i].code == 2'd0) begin
                exp_key = m_key_out; exp_v = m_v_out; exp_ctr = exp_ctr + 32'd1;
            end
            chk($sformatf("v%0d_key", i), gen_key, exp_key);
            chk($sformatf("v%0d_v", i), gen_v, exp_v);
            chk($sformatf("v%0d_ctr", i), gen_reseed_counter, exp_ctr);
        end
        m_err = 1'b0;

        // response held while out_ready stays low
        m_key_out = K2; m_v_out = V2;
        send_req(32'd16, '0);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_first_valid", out_valid, 1);
        d0 = out_data;
        chk("hold_data_value", d0, {16'hA5C3, 240'h0});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, d0);
        end
        get_resp(d, code, err);
        chk("hold_code", code, 0);

        // reseed interval exceeded: requests stall until a load
        m_ctr_ovr = 1'b1; m_ctr_val = RI + 32'd1;
        send_req(32'd32, '0);
        get_resp(d, code, err);
        chk("rs_required", reseed_required, 1);
        chk("rs_ctr", gen_reseed_counter, RI + 32'd1);
        m_ctr_ovr = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_bits = 32'd32; req_addin = '0;
        s0 = start_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rs_stall_ready", req_ready, 0);
        end
        chk("rs_stall_starts", start_cnt - s0, 0);
        load_valid = 1'b1; load_key = K3; load_v = V3;
        #1;
        chk("rs_load_ready", load_ready, 1);
        chk("rs_load_wins", req_ready, 0);
        @(negedge clk);
        load_valid = 1'b0;
        chk("rs_ctr_reload", gen_reseed_counter, 1);
        chk("rs_cleared", reseed_required, 0);
        chk("rs_key", gen_key, K3);
        #1;
        chk("rs_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        get_resp(d, code, err);
        chk("rs_resp_code", code, 0);
        chk("rs_resp_starts", start_cnt - s0, 1);
        chk("rs_resp_ctr", gen_reseed_counter, 2);

        // reset while waiting on generate_drbg
        m_respond = 1'b0;
        s0 = start_cnt;
        send_req(32'd64, '0);
        n = 0;
        while (start_cnt == s0 && n < 20) begin @(negedge clk); n++; end
        chk("wait_started", start_cnt - s0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_inst", instantiated, 0);
        chk("arst_key", gen_key, 0);
        chk("arst_v", gen_v, 0);
        chk("arst_ctr", gen_reseed_counter, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_load_ready", load_ready, 1);
        chk("arst_req_ready", req_ready, 0);
        s1 = start_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("arst_no_resp", out_valid, 0);
        end
        chk("arst_no_restart", start_cnt - s1, 0);

`ifdef DRBG_TIMEOUT_EN
        // watchdog with gen_done withheld
        do_load(K1, V1);
        send_req(32'd32, '0);
        n = 0;
        while (!out_valid && n < 4 * TO) begin @(negedge clk); n++; end
        chk("to_valid", out_valid, 1);
        chk("to_latency", cyc - start_cyc, TO);
        get_resp(d, code, err);
        chk("to_code", code, 3);
        chk("to_err", err, 1);
        chk("to_data", d, 0);
        chk("to_key", gen_key, K1);
        chk("to_ctr", gen_reseed_counter, 1);
        @(negedge clk);
        m_kick = 1'b1;
        @(negedge clk);
        m_kick = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_done_valid", out_valid, 0);
        chk("late_done_key", gen_key, K1);
        m_respond = 1'b1; m_key_out = K2;
        send_req(32'd8, '0);
        get_resp(d, code, err);
        chk("after_to_code", code, 0);
        chk("after_to_data", d, {8'hA5, 248'h0});
        chk("after_to_key", gen_key, K2);
`else
        // without the watchdog a missing gen_done leaves WAIT pending
        do_load(K1, V1);
        send_req(32'd32, '0);
        repeat (3 * TO) @(negedge clk);
        chk("nowd_no_resp", out_valid, 0);
        chk("nowd_key", gen_key, K1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("nowd_rst_out_valid", out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
